// File: rtl/memory_arbiter_n_pkg.sv
// Shared types for the N-core memory arbiter: RAM handshake states, arbiter FSM
// states and the select-width helper used to size core indices.
package memory_arbiter_n_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Prefixed so the literals do not collide with ramstate_t::BUSY.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_n_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbiter
    import memory_arbiter_n_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned SELW = sel_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    localparam int unsigned SUMW = SELW + 1;

    logic [SUMW-1:0] sum;
    logic [SELW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        sum  = '0;
        cand = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + SUMW'(i);
            if (sum >= SUMW'(N)) begin
                sum = sum - SUMW'(N);
            end
            cand = sum[SELW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/memory_arbiter_n.sv
// N-core memory arbiter: merges per-core instruction/data requests onto one RAM
// port with data-first round-robin, retries on ERROR, and raises a sticky halt.
module memory_arbiter_n
    import memory_arbiter_n_pkg::*;
#(
    parameter int unsigned CPUS = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CPUS-1:0]      iren,
    input  logic [CPUS*AW-1:0]   iaddr,
    input  logic [CPUS-1:0]      dren,
    input  logic [CPUS-1:0]      dwen,
    input  logic [CPUS*AW-1:0]   daddr,
    input  logic [CPUS*DW-1:0]   dstore,
    input  logic [CPUS-1:0]      flushed,
    output logic [CPUS-1:0]      iwait,
    output logic [CPUS-1:0]      dwait,
    output logic [DW-1:0]        iload,
    output logic [DW-1:0]        dload,
    output logic [AW-1:0]        ramaddr,
    output logic [DW-1:0]        ramstore,
    output logic                 ramren,
    output logic                 ramwen,
    input  logic [DW-1:0]        ramload,
    input  ramstate_t            ramstate,
    output logic                 halt
);

    localparam int unsigned SELW = sel_width(CPUS);

    // Parameter-dependent width, so the grant type lives with the instance.
    typedef struct packed {
        logic            valid;
        logic            is_data;
        logic [SELW-1:0] core;
    } arb_grant_t;

    arb_state_t      state, state_n;
    arb_grant_t      grant, grant_n;
    logic [SELW-1:0] dptr, dptr_n, iptr, iptr_n;

    logic [CPUS-1:0] dreq;
    logic [CPUS-1:0] dgnt, ignt;
    logic [SELW-1:0] didx, iidx;
    logic            dany, iany;
    logic            cur_req, cur_wr, done_c;
    logic            unused_gnt;

    logic [AW-1:0] iaddr_a  [CPUS];
    logic [AW-1:0] daddr_a  [CPUS];
    logic [DW-1:0] dstore_a [CPUS];

    for (genvar k = 0; k < CPUS; k++) begin : g_unpack
        assign iaddr_a[k]  = iaddr[k*AW +: AW];
        assign daddr_a[k]  = daddr[k*AW +: AW];
        assign dstore_a[k] = dstore[k*DW +: DW];
    end

    // A write on the same core overrides a read.
    assign dreq = dren | dwen;

    rr_arbiter #(.N(CPUS)) u_darb (
        .req (dreq),
        .ptr (dptr),
        .gnt (dgnt),
        .idx (didx),
        .any (dany)
    );

    rr_arbiter #(.N(CPUS)) u_iarb (
        .req (iren),
        .ptr (iptr),
        .gnt (ignt),
        .idx (iidx),
        .any (iany)
    );

    assign unused_gnt = ^{dgnt, ignt};

    assign iload = ramload;
    assign dload = ramload;

    // RAM port follows the granted source live, so a dropped request frees the bus at once.
    always_comb begin
        cur_req  = 1'b0;
        cur_wr   = 1'b0;
        ramren   = 1'b0;
        ramwen   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (grant.valid) begin
            if (grant.is_data) begin
                cur_req  = dreq[grant.core];
                cur_wr   = dwen[grant.core];
                ramaddr  = daddr_a[grant.core];
                ramstore = dstore_a[grant.core];
            end else begin
                cur_req  = iren[grant.core];
                ramaddr  = iaddr_a[grant.core];
            end
            ramren = cur_req & ~cur_wr;
            ramwen = cur_req & cur_wr;
        end
    end

    assign done_c = cur_req & (ramstate == ACCESS);

    always_comb begin
        iwait = iren;
        dwait = dreq;
        if (done_c) begin
            if (grant.is_data) begin
                dwait[grant.core] = 1'b0;
            end else begin
                iwait[grant.core] = 1'b0;
            end
        end
    end

    // Next-state: grant in IDLE, release on ACCESS or drop, hold on ERROR/BUSY/FREE.
    always_comb begin
        state_n = state;
        grant_n = grant;
        dptr_n  = dptr;
        iptr_n  = iptr;
        case (state)
            ARB_IDLE: begin
                if (dany) begin
                    grant_n.valid   = 1'b1;
                    grant_n.is_data = 1'b1;
                    grant_n.core    = didx;
                    state_n         = ARB_BUSY;
                end else if (iany) begin
                    grant_n.valid   = 1'b1;
                    grant_n.is_data = 1'b0;
                    grant_n.core    = iidx;
                    state_n         = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!cur_req) begin
                    grant_n = '0;
                    state_n = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    grant_n = '0;
                    state_n = ARB_IDLE;
                    if (grant.is_data) begin
                        dptr_n = (grant.core == SELW'(CPUS - 1)) ? '0 : grant.core + SELW'(1);
                    end else begin
                        iptr_n = (grant.core == SELW'(CPUS - 1)) ? '0 : grant.core + SELW'(1);
                    end
                end
            end
            default: begin
                grant_n = '0;
                state_n = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            grant <= '0;
            dptr  <= '0;
            iptr  <= '0;
            halt  <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            dptr  <= dptr_n;
            iptr  <= iptr_n;
            halt  <= halt | (&flushed);
        end
    end

endmodule
